// File: rtl/ahb_host_pkg.sv
// ahb_host_pkg: shared FSM states, HSIZE encodings and command layout for the AHB host command queue.
package ahb_host_pkg;

    typedef enum logic {IDLE, ACTIVE} state_t;

    localparam logic [2:0] HSIZE_BYTE = 3'd0;
    localparam logic [2:0] HSIZE_HALF = 3'd1;
    localparam logic [2:0] HSIZE_WORD = 3'd2;

    localparam int HOST_ADDR_W = 32;
    localparam int HOST_DATA_W = 32;

    typedef struct packed {
        logic                   write;
        logic [2:0]             size;
        logic [HOST_ADDR_W-1:0] addr;
        logic [HOST_DATA_W-1:0] wdata;
    } host_cmd_t;

    function automatic logic size_ok(input logic [2:0] size);
        return size <= HSIZE_WORD;
    endfunction

endpackage

// File: rtl/ahb_sync_fifo.sv
// ahb_sync_fifo: power-of-2 synchronous FIFO with head and next-entry peek.
// A push into a full FIFO is taken only when a pop happens in the same cycle.
module ahb_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic [WIDTH-1:0]           rdata_nxt,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d, rd_nxt;
    logic [AW:0]      cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign full      = cnt_q == (AW+1)'(DEPTH);
    assign empty     = cnt_q == '0;
    assign count     = cnt_q;
    assign rd_nxt    = rd_q + 1'b1;
    assign rdata     = mem_q[rd_q];
    assign rdata_nxt = mem_q[rd_nxt];

    always_comb begin
        do_pop  = pop && !empty;
        do_push = push && (!full || do_pop);
        wr_d    = do_push ? wr_q + 1'b1 : wr_q;
        rd_d    = do_pop ? rd_nxt : rd_q;
        cnt_d   = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= wdata;
    end

endmodule

// File: rtl/ahb_host_cmd_queue.sv
// ahb_host_cmd_queue: buffers client commands, issues them one at a time on the host_* port of an
// ahb_master and returns read data. Optional watchdog enabled by HOST_CMD_TIMEOUT_EN.
module ahb_host_cmd_queue
    import ahb_host_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int CMD_DEPTH = 4,
    parameter int RSP_DEPTH = 4,
    parameter int TIMEOUT   = 255
) (
    input  logic              hclk,
    input  logic              hreset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [2:0]        cmd_size,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              host_read,
    output logic              host_write,
    output logic              host_cont,
    output logic [2:0]        host_size,
    output logic [ADDR_W-1:0] host_addr,
    output logic [DATA_W-1:0] host_wdata,
    input  logic [DATA_W-1:0] bus_rdata,
    input  logic              bus_rdone,
    input  logic              bus_wready,
    output logic              busy
);
    localparam int CW  = 4 + ADDR_W + DATA_W;
    localparam int CCW = $clog2(CMD_DEPTH) + 1;
    localparam int RCW = $clog2(RSP_DEPTH) + 1;

    logic [CW-1:0]     cmd_head, cmd_nxt;
    logic              cmd_full, cmd_empty, cmd_pop;
    logic [CCW-1:0]    cmd_cnt;
    logic [DATA_W:0]   rsp_head;
    logic              rsp_full, rsp_empty, rsp_push, rsp_err_in;
    logic [DATA_W-1:0] rsp_data_in;
    logic [RCW-1:0]    rsp_cnt;

    logic              hd_write, nx_write;
    logic [2:0]        hd_size, nx_size;
    logic [ADDR_W-1:0] hd_addr, nx_addr;
    logic [DATA_W-1:0] hd_wdata, nx_wdata;
    logic              hd_ok, nx_ok, seq, done;

    state_t            state_q, state_d;
    logic              rd_q, rd_d, wr_q, wr_d, cont_q, cont_d;
    logic [2:0]        size_q, size_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
`ifdef HOST_CMD_TIMEOUT_EN
    localparam int WDW = $clog2(TIMEOUT + 1);
    logic [WDW-1:0]    wd_q, wd_d;
`endif

    ahb_sync_fifo #(.WIDTH(CW), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
        .clk(hclk), .rst(hreset), .push(cmd_valid && !cmd_full),
        .wdata({cmd_write, cmd_size, cmd_addr, cmd_wdata}), .pop(cmd_pop),
        .rdata(cmd_head), .rdata_nxt(cmd_nxt), .full(cmd_full), .empty(cmd_empty), .count(cmd_cnt)
    );

    ahb_sync_fifo #(.WIDTH(DATA_W + 1), .DEPTH(RSP_DEPTH)) u_rsp_fifo (
        .clk(hclk), .rst(hreset), .push(rsp_push), .wdata({rsp_err_in, rsp_data_in}),
        .pop(rsp_ready), .rdata(rsp_head), .rdata_nxt(), .full(rsp_full), .empty(rsp_empty),
        .count(rsp_cnt)
    );

    assign {hd_write, hd_size, hd_addr, hd_wdata} = cmd_head;
    assign {nx_write, nx_size, nx_addr, nx_wdata} = cmd_nxt;

    assign hd_ok = !cmd_empty && (hd_write || !rsp_full);
    // A read completing this cycle occupies one response slot before the next head can be judged.
    assign nx_ok = cmd_cnt >= CCW'(2) && size_ok(nx_size) &&
                   (nx_write || (rd_q ? rsp_cnt < RCW'(RSP_DEPTH - 1) : !rsp_full));
    assign seq   = nx_write == wr_q && nx_size == size_q && nx_addr == addr_q + (ADDR_W'(1) << size_q);
    assign done  = wr_q ? bus_wready : bus_rdone;

    always_comb begin
        state_d     = state_q;
        rd_d        = rd_q;
        wr_d        = wr_q;
        cont_d      = cont_q;
        size_d      = size_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        cmd_pop     = 1'b0;
        rsp_push    = 1'b0;
        rsp_err_in  = 1'b0;
        rsp_data_in = '0;
`ifdef HOST_CMD_TIMEOUT_EN
        wd_d        = wd_q;
`endif
        if (state_q == IDLE) begin
            if (hd_ok && !size_ok(hd_size)) begin
                cmd_pop    = 1'b1;
                rsp_push   = !hd_write;
                rsp_err_in = 1'b1;
            end else if (hd_ok) begin
                state_d = ACTIVE;
                rd_d    = !hd_write;
                wr_d    = hd_write;
                cont_d  = 1'b0;
                size_d  = hd_size;
                addr_d  = hd_addr;
                wdata_d = hd_wdata;
`ifdef HOST_CMD_TIMEOUT_EN
                wd_d    = '0;
`endif
            end
        end else if (done) begin
            cmd_pop     = 1'b1;
            rsp_push    = rd_q;
            rsp_data_in = bus_rdata;
            state_d     = nx_ok ? ACTIVE : IDLE;
            rd_d        = nx_ok && !nx_write;
            wr_d        = nx_ok && nx_write;
            cont_d      = nx_ok && seq;
            size_d      = nx_ok ? nx_size : size_q;
            addr_d      = nx_ok ? nx_addr : addr_q;
            wdata_d     = nx_ok ? nx_wdata : wdata_q;
`ifdef HOST_CMD_TIMEOUT_EN
            wd_d        = '0;
        end else if (wd_q == WDW'(TIMEOUT - 1)) begin
            cmd_pop    = 1'b1;
            rsp_push   = rd_q;
            rsp_err_in = 1'b1;
            state_d    = IDLE;
            rd_d       = 1'b0;
            wr_d       = 1'b0;
            cont_d     = 1'b0;
        end else begin
            wd_d = wd_q + 1'b1;
`endif
        end
    end

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            state_q <= IDLE;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            cont_q  <= 1'b0;
            size_q  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
`ifdef HOST_CMD_TIMEOUT_EN
            wd_q    <= '0;
`endif
        end else begin
            state_q <= state_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            cont_q  <= cont_d;
            size_q  <= size_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
`ifdef HOST_CMD_TIMEOUT_EN
            wd_q    <= wd_d;
`endif
        end
    end

    assign cmd_ready  = !cmd_full;
    assign rsp_valid  = !rsp_empty;
    assign rsp_rdata  = rsp_valid ? rsp_head[DATA_W-1:0] : '0;
    assign rsp_err    = rsp_valid && rsp_head[DATA_W];
    assign host_read  = rd_q;
    assign host_write = wr_q;
    assign host_cont  = cont_q;
    assign host_size  = size_q;
    assign host_addr  = addr_q;
    assign host_wdata = wdata_q;
    assign busy       = !cmd_empty || state_q == ACTIVE || !rsp_empty;

endmodule

// File: tb/tb_ahb_host_cmd_queue.sv
// tb_ahb_host_cmd_queue: directed self-checking bench for ahb_host_cmd_queue (4-deep FIFOs, TIMEOUT=8).
module tb_ahb_host_cmd_queue;
    logic        hclk = 1'b0;
    logic        hreset;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [2:0]  cmd_size;
    logic [31:0] cmd_addr, cmd_wdata;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_rdata;
    logic        host_read, host_write, host_cont;
    logic [2:0]  host_size;
    logic [31:0] host_addr, host_wdata;
    logic [31:0] bus_rdata;
    logic        bus_rdone, bus_wready, busy;

    int n_chk = 0;
    int n_fail = 0;

    localparam logic [31:0] KEY = 32'h5A5A_0000;

    ahb_host_cmd_queue #(.ADDR_W(32), .DATA_W(32), .CMD_DEPTH(4), .RSP_DEPTH(4), .TIMEOUT(8)) dut (
        .hclk(hclk), .hreset(hreset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_write(cmd_write), .cmd_size(cmd_size), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .host_read(host_read), .host_write(host_write), .host_cont(host_cont),
        .host_size(host_size), .host_addr(host_addr), .host_wdata(host_wdata),
        .bus_rdata(bus_rdata), .bus_rdone(bus_rdone), .bus_wready(bus_wready), .busy(busy)
    );

    always #5 hclk = ~hclk;

    task automatic tick();
        @(posedge hclk);
        #1;
    endtask

    task automatic push(input logic w, input logic [2:0] s, input logic [31:0] a, input logic [31:0] d);
        logic rdy;
        logic ok;
        ok = 1'b0;
        cmd_valid = 1'b1; cmd_write = w; cmd_size = s; cmd_addr = a; cmd_wdata = d;
        for (int i = 0; i < 60 && !ok; i++) begin
            rdy = cmd_ready;
            tick();
            ok = rdy;
        end
        cmd_valid = 1'b0;
        if (!ok) begin
            n_chk++; n_fail++;
            $display("FAIL push_accept: addr %h not accepted within 60 cycles (required accepted)", a);
        end
    endtask

    task automatic test_reset();
        n_chk++;
        if ({cmd_ready, rsp_valid, host_read, host_write, host_cont, busy} !== 6'b100000) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b required 100000", {cmd_ready, rsp_valid, host_read, host_write, host_cont, busy});
        end
        push(1'b0, 3'd2, 32'h0000_0080, 32'h0);
        tick();
        n_chk++;
        if (host_read !== 1'b1) begin n_fail++; $display("FAIL reset_pre_read: host_read got %b required 1", host_read); end
        hreset = 1'b1;
        #1;
        n_chk++;
        if (host_read !== 1'b0) begin n_fail++; $display("FAIL reset_async_drop: host_read got %b required 0", host_read); end
        tick();
        tick();
        hreset = 1'b0;
        tick();
        tick();
        n_chk++;
        if ({cmd_ready, rsp_valid, host_read, busy} !== 4'b1000) begin
            n_fail++;
            $display("FAIL reset_release: cmd_ready/rsp_valid/host_read/busy got %b required 1000", {cmd_ready, rsp_valid, host_read, busy});
        end
    endtask

    task automatic test_write();
        push(1'b1, 3'd2, 32'h0000_0100, 32'hDEAD_BEEF);
        n_chk++;
        if (host_write !== 1'b0) begin n_fail++; $display("FAIL write_latency_k: host_write got %b required 0", host_write); end
        tick();
        n_chk++;
        if ({host_write, host_read, host_cont, host_size, host_addr, host_wdata} !== {3'b100, 3'd2, 32'h100, 32'hDEAD_BEEF}) begin
            n_fail++;
            $display("FAIL write_issue: w/r/c %b%b%b size %0d addr %h wdata %h required 100 2 00000100 deadbeef",
                     host_write, host_read, host_cont, host_size, host_addr, host_wdata);
        end
        tick();
        tick();
        n_chk++;
        if (host_write !== 1'b1 || host_addr !== 32'h100) begin
            n_fail++; $display("FAIL write_hold: host_write %b addr %h required 1 00000100", host_write, host_addr);
        end
        bus_wready = 1'b1;
        tick();
        bus_wready = 1'b0;
        n_chk++;
        if ({host_write, busy, rsp_valid} !== 3'b000) begin
            n_fail++; $display("FAIL write_done: host_write/busy/rsp_valid got %b required 000", {host_write, busy, rsp_valid});
        end
    endtask

    task automatic test_reads();
        logic [31:0] a_exp [3];
        logic        c_exp [3];
        a_exp = '{32'h200, 32'h204, 32'h208};
        c_exp = '{1'b0, 1'b1, 1'b1};
        push(1'b0, 3'd2, 32'h200, 32'h0);
        push(1'b0, 3'd2, 32'h204, 32'h0);
        push(1'b0, 3'd2, 32'h208, 32'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            n_chk++;
            if (host_read !== 1'b1 || host_addr !== a_exp[i] || host_cont !== c_exp[i]) begin
                n_fail++;
                $display("FAIL read_seq_%0d: read %b addr %h cont %b required 1 %h %b", i, host_read, host_addr, host_cont, a_exp[i], c_exp[i]);
            end
            bus_rdone = 1'b1;
            bus_rdata = 32'h1111_0000 + i;
            tick();
            bus_rdone = 1'b0;
        end
        n_chk++;
        if (host_read !== 1'b0) begin n_fail++; $display("FAIL read_seq_idle: host_read got %b required 0", host_read); end
        for (int i = 0; i < 3; i++) begin
            n_chk++;
            if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== 32'h1111_0000 + i) begin
                n_fail++;
                $display("FAIL read_rsp_%0d: valid %b err %b rdata %h required 1 0 %h", i, rsp_valid, rsp_err, rsp_rdata, 32'h1111_0000 + i);
            end
            rsp_ready = 1'b1;
            tick();
            rsp_ready = 1'b0;
        end
        n_chk++;
        if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL read_rsp_drain: rsp_valid got %b required 0", rsp_valid); end
    endtask

    task automatic test_rsp_full();
        int n_done;
        int j;
        n_done = 0;
        rsp_ready = 1'b0;
        fork
            for (int i = 0; i < 6; i++) push(1'b0, 3'd2, 32'h300 + 4 * i, 32'h0);
            begin
                for (int c = 0; c < 30; c++) begin
                    bus_rdone = host_read;
                    bus_rdata = host_addr ^ KEY;
                    if (host_read) n_done++;
                    tick();
                end
                bus_rdone = 1'b0;
            end
        join
        n_chk++;
        if (n_done != 4) begin n_fail++; $display("FAIL rsp_full_issued: got %0d reads required 4", n_done); end
        n_chk++;
        if ({host_read, rsp_valid, busy} !== 3'b011) begin
            n_fail++; $display("FAIL rsp_full_stall: read/rsp_valid/busy got %b required 011", {host_read, rsp_valid, busy});
        end
        n_chk++;
        if (rsp_rdata !== (32'h300 ^ KEY)) begin n_fail++; $display("FAIL rsp_full_rsp_0: got %h required %h", rsp_rdata, 32'h300 ^ KEY); end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        n_chk++;
        if (host_read !== 1'b0) begin n_fail++; $display("FAIL rsp_full_early: host_read got %b required 0", host_read); end
        tick();
        n_chk++;
        if (host_read !== 1'b1 || host_addr !== 32'h310) begin
            n_fail++; $display("FAIL rsp_full_fifth: read %b addr %h required 1 00000310", host_read, host_addr);
        end
        j = 1;
        rsp_ready = 1'b1;
        for (int c = 0; c < 40; c++) begin
            bus_rdone = host_read;
            bus_rdata = host_addr ^ KEY;
            if (rsp_valid) begin
                n_chk++;
                if (rsp_rdata !== ((32'h300 + 4 * j) ^ KEY) || rsp_err !== 1'b0) begin
                    n_fail++; $display("FAIL rsp_full_rsp_%0d: rdata %h err %b required %h 0", j, rsp_rdata, rsp_err, (32'h300 + 4 * j) ^ KEY);
                end
                j++;
            end
            tick();
        end
        bus_rdone = 1'b0;
        rsp_ready = 1'b0;
        n_chk++;
        if (j != 6 || busy !== 1'b0) begin n_fail++; $display("FAIL rsp_full_count: got %0d responses busy %b required 6 0", j, busy); end
    endtask

    task automatic test_cont();
        push(1'b1, 3'd2, 32'h10, 32'hAAAA_5555);
        push(1'b0, 3'd2, 32'h14, 32'h0);
        bus_wready = 1'b1;
        tick();
        bus_wready = 1'b0;
        n_chk++;
        if (host_read !== 1'b1 || host_addr !== 32'h14 || host_cont !== 1'b0) begin
            n_fail++; $display("FAIL cont_dir_change: read %b addr %h cont %b required 1 00000014 0", host_read, host_addr, host_cont);
        end
        bus_rdone = 1'b1;
        bus_rdata = 32'hCAFE_0014;
        tick();
        bus_rdone = 1'b0;
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        push(1'b1, 3'd2, 32'hFFFF_FFFC, 32'h1);
        push(1'b1, 3'd2, 32'h0000_0000, 32'h2);
        n_chk++;
        if (host_write !== 1'b1 || host_addr !== 32'hFFFF_FFFC || host_cont !== 1'b0) begin
            n_fail++; $display("FAIL cont_wrap_first: write %b addr %h cont %b required 1 fffffffc 0", host_write, host_addr, host_cont);
        end
        bus_wready = 1'b1;
        tick();
        n_chk++;
        if (host_write !== 1'b1 || host_addr !== 32'h0 || host_cont !== 1'b1 || host_wdata !== 32'h2) begin
            n_fail++; $display("FAIL cont_wrap: write %b addr %h cont %b wdata %h required 1 00000000 1 00000002", host_write, host_addr, host_cont, host_wdata);
        end
        tick();
        bus_wready = 1'b0;
        n_chk++;
        if (host_write !== 1'b0 || host_cont !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL cont_idle: write/cont/busy got %b required 000", {host_write, host_cont, busy});
        end
    endtask

    task automatic test_illegal();
        push(1'b0, 3'd3, 32'h40, 32'h0);
        tick();
        n_chk++;
        if ({rsp_valid, rsp_err, host_read} !== 3'b110 || rsp_rdata !== 32'h0) begin
            n_fail++; $display("FAIL illegal_read: valid/err/read %b rdata %h required 110 00000000", {rsp_valid, rsp_err, host_read}, rsp_rdata);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        push(1'b1, 3'd5, 32'h44, 32'h1234);
        tick();
        n_chk++;
        if ({host_write, rsp_valid, busy} !== 3'b000) begin
            n_fail++; $display("FAIL illegal_write: write/rsp_valid/busy got %b required 000", {host_write, rsp_valid, busy});
        end
    endtask

`ifdef HOST_CMD_TIMEOUT_EN
    task automatic test_timeout();
        int n_hi;
        n_hi = 0;
        push(1'b0, 3'd2, 32'h500, 32'h0);
        tick();
        for (int c = 0; c < 20; c++) begin
            if (host_read) n_hi++;
            tick();
        end
        n_chk++;
        if (n_hi != 8) begin n_fail++; $display("FAIL timeout_cycles: host_read high %0d cycles required 8", n_hi); end
        n_chk++;
        if ({rsp_valid, rsp_err} !== 2'b11 || rsp_rdata !== 32'h0) begin
            n_fail++; $display("FAIL timeout_rsp: valid/err %b rdata %h required 11 00000000", {rsp_valid, rsp_err}, rsp_rdata);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask
`endif

    initial begin
        hreset = 1'b1;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_size = 3'd0; cmd_addr = '0; cmd_wdata = '0;
        rsp_ready = 1'b0; bus_rdata = '0; bus_rdone = 1'b0; bus_wready = 1'b0;
        tick();
        tick();
        hreset = 1'b0;
        tick();
        test_reset();
        test_write();
        test_reads();
        test_rsp_full();
        test_cont();
        test_illegal();
`ifdef HOST_CMD_TIMEOUT_EN
        test_timeout();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
